// File: rtl/nor_sub_pipe.sv
// Normalise/subnormal pipeline register with valid/ready handshake, 2-entry skid, flush, occupancy and stall counter.
// Optional flush-to-zero on capture is enabled by defining NOR_SUB_FTZ_EN.
module nor_sub_pipe #(
    parameter int MANT_W  = 11,
    parameter int EXP_W   = 7,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic [MANT_W-1:0]  norm_sum_in,
    input  logic [EXP_W-1:0]   exp_final_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_out,
    output logic [MANT_W-1:0]  norm_sum_out,
    output logic [EXP_W-1:0]   exp_final_out,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef struct packed {
        logic              sign;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  expo;
    } word_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    word_t              main_q, main_d;
    word_t              skid_q, skid_d;
    word_t              in_word, cap_word;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               in_fire, out_fire;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[1] | state_q[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign in_word = '{sign: sign_in, mant: norm_sum_in, expo: exp_final_in};

    always_comb begin
        cap_word = in_word;
`ifdef NOR_SUB_FTZ_EN
        if (in_word.expo == '0) begin
            cap_word.mant = '0;
        end
`endif
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = cap_word;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = cap_word;
                end else if (in_fire) begin
                    skid_d  = cap_word;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Skid entry was filtered at capture; moving it is a plain copy.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end

        // Flush wins over any simultaneous transfer; data words are left as don't-care.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
            stall_d = '0;
        end
    end

    // NOTE: data registers are reset too, so outputs read as zero right after reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign sign_out      = main_q.sign;
    assign norm_sum_out  = main_q.mant;
    assign exp_final_out = main_q.expo;
    assign occupancy     = state_q;
    assign stall_cnt     = stall_q;

    a_legal_state : assert property (@(posedge clk) disable iff (!rst)
        state_q inside {EMPTY, BUSY, FULL});

    a_hold_when_stalled : assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush) |=> $stable(main_q));

endmodule

// File: tb/tb_nor_sub_pipe.sv
// Scoreboard bench for nor_sub_pipe: words are queued on acceptance and compared as they leave.
module tb_nor_sub_pipe;

    localparam int MW = 11;
    localparam int EW = 7;
    localparam int SW = 8;
    localparam int WW = 1 + MW + EW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sign_in = 1'b0;
    logic [MW-1:0] norm_sum_in = '0;
    logic [EW-1:0] exp_final_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          sign_out;
    logic [MW-1:0] norm_sum_out;
    logic [EW-1:0] exp_final_out;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    logic [WW-1:0] sb_q[$];

    always #5 clk = ~clk;

    nor_sub_pipe #(.MANT_W(MW), .EXP_W(EW), .STALL_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sign_in      (sign_in),
        .norm_sum_in  (norm_sum_in),
        .exp_final_in (exp_final_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sign_out     (sign_out),
        .norm_sum_out (norm_sum_out),
        .exp_final_out(exp_final_out),
        .occupancy    (occupancy),
        .stall_cnt    (stall_cnt)
    );

    function automatic logic [WW-1:0] mk(input logic s, input logic [MW-1:0] m, input logic [EW-1:0] e);
        return {s, m, e};
    endfunction

    function automatic logic [WW-1:0] model(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = w;
`ifdef NOR_SUB_FTZ_EN
        if (w[EW-1:0] == '0) r[MW+EW-1:EW] = '0;
`endif
        return r;
    endfunction

    // Output side of the scoreboard: every transfer must match the oldest accepted word.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb_q.delete();
        end else if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h required=none", {sign_out, norm_sum_out, exp_final_out});
            end else begin
                logic [WW-1:0] e;
                e = sb_q.pop_front();
                if ({sign_out, norm_sum_out, exp_final_out} !== e) begin
                    failures++;
                    $display("FAIL sb_order got=%h required=%h", {sign_out, norm_sum_out, exp_final_out}, e);
                end
            end
        end
    end

    // Drive one cycle of inputs, then sit at the falling edge for checks.
    task automatic apply(input logic v, input logic [WW-1:0] w, input logic ordy, input logic fl);
        in_valid = v;
        {sign_in, norm_sum_in, exp_final_in} = w;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        if (rst && !fl && v && in_ready) sb_q.push_back(model(w));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, mk(1'b1, 11'h7FF, 7'h7F), 1'b0, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
            checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occupancy got=%0d required=0", occupancy); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
            checks++; if ({sign_out, norm_sum_out, exp_final_out, stall_cnt} !== '0) begin
                failures++; $display("FAIL rst_data got=%h required=0", {sign_out, norm_sum_out, exp_final_out, stall_cnt});
            end
            advance();
        end
        rst = 1'b1;
        apply(1'b1, mk(1'b1, 11'h5A3, 7'h3F), 1'b1, 1'b0);
        advance();
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_latency got=%b required=1", out_valid); end
        checks++; if ({sign_out, norm_sum_out, exp_final_out} !== mk(1'b1, 11'h5A3, 7'h3F)) begin
            failures++; $display("FAIL first_word got=%h required=%h", {sign_out, norm_sum_out, exp_final_out}, mk(1'b1, 11'h5A3, 7'h3F));
        end
        advance();
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL first_drain got=%0d required=0", occupancy); end
        advance();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            apply(1'b1, mk(1'b0, 11'(i), 7'h10), 1'b1, 1'b0);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready i=%0d got=%b required=1", i, in_ready); end
            if (i > 1) begin
                checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ i=%0d got=%0d required=1", i, occupancy); end
                checks++; if (norm_sum_out !== 11'(i - 1)) begin failures++; $display("FAIL stream_mant i=%0d got=%h required=%h", i, norm_sum_out, 11'(i - 1)); end
            end
            advance();
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (norm_sum_out !== 11'd8) begin failures++; $display("FAIL stream_last got=%h required=8", norm_sum_out); end
        advance();
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL stream_left got=%0d required=0", sb_q.size()); end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] wa, wb, wc;
        int acc_at;
        wa = mk(1'b0, 11'h101, 7'h05);
        wb = mk(1'b1, 11'h202, 7'h06);
        wc = mk(1'b0, 11'h303, 7'h07);
        apply(1'b1, wa, 1'b0, 1'b0);
        advance();
        apply(1'b1, wb, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_b_ready got=%b required=1", in_ready); end
        advance();
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, wc, 1'b0, 1'b0);
            checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_full_occ got=%0d required=2", occupancy); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b required=0", in_ready); end
            checks++; if ({sign_out, norm_sum_out, exp_final_out} !== wa) begin
                failures++; $display("FAIL bp_hold got=%h required=%h", {sign_out, norm_sum_out, exp_final_out}, wa);
            end
            advance();
        end
        acc_at = -1;
        for (int k = 0; k < 6 && acc_at < 0; k++) begin
            apply(1'b1, wc, 1'b1, 1'b0);
            if (in_ready) acc_at = k;
            advance();
        end
        checks++; if (acc_at !== 1) begin failures++; $display("FAIL bp_reaccept got=%0d required=1", acc_at); end
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            advance();
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (sb_q.size() != 0 || occupancy !== 2'd0) begin
            failures++; $display("FAIL bp_drain got=%0d/%0d required=0/0", sb_q.size(), occupancy);
        end
        advance();
    endtask

    task automatic test_stall_counter();
        apply(1'b0, '0, 1'b1, 1'b1);
        advance();
        apply(1'b1, mk(1'b1, 11'h0AA, 7'h01), 1'b0, 1'b0);
        checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL stall_start got=%0d required=0", stall_cnt); end
        advance();
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
        apply(1'b0, '0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 8'd10) begin failures++; $display("FAIL stall_count got=%0d required=10", stall_cnt); end
        advance();
        for (int k = 0; k < 295; k++) begin
            apply(1'b0, '0, 1'b0, 1'b0);
            advance();
        end
        apply(1'b0, '0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 8'd255) begin failures++; $display("FAIL stall_sat got=%0d required=255", stall_cnt); end
        checks++; if (norm_sum_out !== 11'h0AA) begin failures++; $display("FAIL stall_stable got=%h required=0aa", norm_sum_out); end
        advance();
        apply(1'b0, '0, 1'b0, 1'b1);
        advance();
        apply(1'b0, '0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL stall_flush got=%0d required=0", stall_cnt); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_flush_hs got=%b%b required=01", out_valid, in_ready);
        end
        advance();
    endtask

    task automatic test_flush_priority();
        apply(1'b1, mk(1'b0, 11'h111, 7'h11), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(1'b0, 11'h222, 7'h22), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(1'b1, 11'h333, 7'h33), 1'b1, 1'b1);
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d required=2", occupancy); end
        advance();
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_post got=occ%0d v%b r%b required=occ0 v0 r1", occupancy, out_valid, in_ready);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak k=%0d got=%b required=0", k, out_valid); end
            advance();
        end
    endtask

    task automatic test_ftz();
        logic [MW-1:0] m_exp;
`ifdef NOR_SUB_FTZ_EN
        m_exp = '0;
`else
        m_exp = 11'h3FF;
`endif
        apply(1'b1, mk(1'b0, 11'h3FF, 7'h00), 1'b1, 1'b0);
        advance();
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || norm_sum_out !== m_exp || exp_final_out !== 7'h00) begin
            failures++; $display("FAIL ftz_main got=v%b m%h e%h required=v1 m%h e00", out_valid, norm_sum_out, exp_final_out, m_exp);
        end
        advance();
        // Same rule through the skid entry; the scoreboard checks the drained words.
        apply(1'b1, mk(1'b0, 11'h155, 7'h02), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(1'b1, 11'h2AA, 7'h00), 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            advance();
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL ftz_drain got=%0d required=0", sb_q.size()); end
        advance();
    endtask

    task automatic test_reset_mid();
        apply(1'b1, mk(1'b0, 11'h444, 7'h44), 1'b0, 1'b0);
        advance();
        apply(1'b1, mk(1'b1, 11'h555, 7'h55), 1'b0, 1'b0);
        advance();
        rst = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_hs got=occ%0d v%b r%b required=occ0 v0 r1", occupancy, out_valid, in_ready);
        end
        checks++; if ({sign_out, norm_sum_out, exp_final_out, stall_cnt} !== '0) begin
            failures++; $display("FAIL midrst_data got=%h required=0", {sign_out, norm_sum_out, exp_final_out, stall_cnt});
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        advance();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_leak k=%0d got=%b required=0", k, out_valid); end
            advance();
        end
    endtask

    initial begin
        advance();
        test_reset();
        test_streaming();
        test_back_to_back();
        test_stall_counter();
        test_flush_priority();
        test_ftz();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
